// File: rtl/vscale_hasti_master_pkg.sv
// Shared AHB-Lite (HASTI) bus constants and types for the vscale bus master.
// Every width and encoding used by the master is defined here and nowhere else.
package vscale_hasti_master_pkg;

  localparam int HASTI_BUS_WIDTH   = 32;
  localparam int HASTI_ADDR_WIDTH  = 32;
  localparam int HASTI_SIZE_WIDTH  = 3;
  localparam int HASTI_BURST_WIDTH = 3;
  localparam int HASTI_PROT_WIDTH  = 4;
  localparam int HASTI_TRANS_WIDTH = 2;

  typedef enum logic [HASTI_TRANS_WIDTH-1:0] {
    HASTI_TRANS_IDLE   = 2'b00,
    HASTI_TRANS_BUSY   = 2'b01,
    HASTI_TRANS_NONSEQ = 2'b10,
    HASTI_TRANS_SEQ    = 2'b11
  } hasti_trans_e;

  localparam logic [HASTI_BURST_WIDTH-1:0] HASTI_BURST_SINGLE = 3'd0;

  localparam logic HASTI_RESP_OKAY  = 1'b0;
  localparam logic HASTI_RESP_ERROR = 1'b1;

  localparam logic [HASTI_SIZE_WIDTH-1:0] HASTI_SIZE_BYTE = 3'd0;
  localparam logic [HASTI_SIZE_WIDTH-1:0] HASTI_SIZE_HALF = 3'd1;
  localparam logic [HASTI_SIZE_WIDTH-1:0] HASTI_SIZE_WORD = 3'd2;

  typedef struct packed {
    logic [HASTI_ADDR_WIDTH-1:0] addr;
    logic                        write;
    logic [HASTI_SIZE_WIDTH-1:0] size;
    logic [HASTI_BUS_WIDTH-1:0]  wdata;
  } hasti_ap_t;

  // The master only issues byte, half and word transfers.
  function automatic logic [HASTI_SIZE_WIDTH-1:0] clamp_size(
    input logic [HASTI_SIZE_WIDTH-1:0] size
  );
    return (size > HASTI_SIZE_WORD) ? HASTI_SIZE_WORD : size;
  endfunction

endpackage

// File: rtl/vscale_hasti_master.sv
// Single-transfer AHB-Lite master: converts a valid/ready client request stream
// into pipelined NONSEQ transfers with an address stage and a data stage.
module vscale_hasti_master
  import vscale_hasti_master_pkg::*;
#(
  parameter logic [HASTI_PROT_WIDTH-1:0] HPROT_VAL = 4'b0011
) (
  input  logic                         hclk,
  input  logic                         hresetn,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [HASTI_ADDR_WIDTH-1:0]  req_addr,
  input  logic                         req_write,
  input  logic [HASTI_SIZE_WIDTH-1:0]  req_size,
  input  logic [HASTI_BUS_WIDTH-1:0]   req_wdata,
  output logic                         resp_valid,
  output logic [HASTI_BUS_WIDTH-1:0]   resp_rdata,
  output logic                         resp_err,
  output logic [HASTI_ADDR_WIDTH-1:0]  haddr,
  output logic                         hwrite,
  output logic [HASTI_SIZE_WIDTH-1:0]  hsize,
  output logic [HASTI_BURST_WIDTH-1:0] hburst,
  output logic                         hmastlock,
  output logic [HASTI_PROT_WIDTH-1:0]  hprot,
  output logic [HASTI_TRANS_WIDTH-1:0] htrans,
  output logic [HASTI_BUS_WIDTH-1:0]   hwdata,
  input  logic [HASTI_BUS_WIDTH-1:0]   hrdata,
  input  logic                         hready,
  input  logic                         hresp
);

  hasti_ap_t                  ap_q, ap_d;
  logic                       ap_valid_q, ap_valid_d;
  logic                       dp_valid_q, dp_valid_d;
  logic                       dp_write_q, dp_write_d;
  logic [HASTI_BUS_WIDTH-1:0] dp_wdata_q, dp_wdata_d;

  logic      cancel;
  logic      advance;
  logic      accept;
  hasti_ap_t req_ap;

  // An ERROR response kills the pending address phase so it can be replayed.
  assign cancel  = dp_valid_q && (hresp == HASTI_RESP_ERROR);
  assign advance = hready && !cancel;

  assign req_ready = !ap_valid_q || advance;
  assign accept    = req_valid && req_ready;
  assign req_ap    = '{addr: req_addr, write: req_write,
                       size: clamp_size(req_size), wdata: req_wdata};

  always_comb begin
    ap_d       = ap_q;
    ap_valid_d = ap_valid_q;
    dp_valid_d = dp_valid_q;
    dp_write_d = dp_write_q;
    dp_wdata_d = dp_wdata_q;
    if (advance) begin
      dp_valid_d = ap_valid_q;
      dp_write_d = ap_q.write;
      dp_wdata_d = ap_q.wdata;
      ap_valid_d = accept;
      if (accept) ap_d = req_ap;
    end else begin
      // Here hready implies the final ERROR cycle: retire the failed transfer.
      if (hready) dp_valid_d = 1'b0;
      if (accept) begin
        ap_valid_d = 1'b1;
        ap_d       = req_ap;
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      ap_q       <= '0;
      ap_valid_q <= 1'b0;
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_wdata_q <= '0;
    end else begin
      ap_q       <= ap_d;
      ap_valid_q <= ap_valid_d;
      dp_valid_q <= dp_valid_d;
      dp_write_q <= dp_write_d;
      dp_wdata_q <= dp_wdata_d;
    end
  end

  assign haddr     = ap_q.addr;
  assign hwrite    = ap_q.write;
  assign hsize     = ap_q.size;
  assign htrans    = (ap_valid_q && !cancel) ? HASTI_TRANS_NONSEQ : HASTI_TRANS_IDLE;
  assign hburst    = HASTI_BURST_SINGLE;
  assign hmastlock = 1'b0;
  assign hprot     = HPROT_VAL;
  assign hwdata    = dp_valid_q ? dp_wdata_q : '0;

  assign resp_valid = dp_valid_q && hready;
  assign resp_err   = resp_valid && (hresp == HASTI_RESP_ERROR);
  assign resp_rdata = (resp_valid && !dp_write_q) ? hrdata : '0;

endmodule
